// File: rtl/agdc_multi_mode.sv
// Garage door controller: Moore FSM with limit, obstruction and travel-timeout handling.
// Optional auto-close from the fully-open position is built when AGDC_AUTO_CLOSE_EN is defined.
module agdc_multi_mode #(
    parameter int CNT_W          = 16,
    parameter int TRAVEL_CYC     = 1000,
    parameter int AUTO_CLOSE_CYC = 5000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Activate,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       OBS,
    output logic       UP_M,
    output logic       DN_M,
    output logic       FAULT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MV_UP = 3'd1,
        S_MV_DN = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam longint CNT_MAX_VAL = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);

    // Both counters saturate, so the terminal counts must be representable.
    if (TRAVEL_CYC < 1 || TRAVEL_CYC > CNT_MAX_VAL ||
        AUTO_CLOSE_CYC < 1 || AUTO_CLOSE_CYC > CNT_MAX_VAL) begin : g_bad_cfg
        $error("agdc_multi_mode: cycle parameters must be in 1..2^CNT_W-1");
    end

    state_t           state;
    state_t           state_next;
    logic             act_q;
    logic             act;
    logic             last_dir_up;
    logic [CNT_W-1:0] travel_cnt;
    logic             travel_done;
    logic             limit_conflict;
    logic             entering_motion;
    logic             motor_on;
    logic             auto_done;

    assign act            = Activate & ~act_q;
    assign limit_conflict = UP_Max & DN_Max;
    assign travel_done    = (travel_cnt >= TRAVEL_LAST);
    assign motor_on       = (state == S_MV_UP) || (state == S_MV_DN);
    assign entering_motion = ((state_next == S_MV_UP) && (state != S_MV_UP)) ||
                             ((state_next == S_MV_DN) && (state != S_MV_DN));

`ifdef AGDC_AUTO_CLOSE_EN
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CLOSE_CYC - 1);

    logic [CNT_W-1:0] auto_cnt;
    logic             auto_arm;

    assign auto_arm  = (state == S_IDLE) & UP_Max & ~DN_Max & ~OBS;
    assign auto_done = auto_arm & (auto_cnt >= AUTO_LAST);

    // Counts only while parked fully open with a clear beam; anything else restarts it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            auto_cnt <= '0;
        end else if (auto_arm && (state_next == S_IDLE)) begin
            auto_cnt <= (auto_cnt == '1) ? auto_cnt : auto_cnt + 1'b1;
        end else begin
            auto_cnt <= '0;
        end
    end
`else
    assign auto_done = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (auto_done) begin
                    state_next = S_MV_DN;
                end else if (act) begin
                    // Mid-travel (no limit asserted) opens, as does the closed position.
                    state_next = (DN_Max || !UP_Max) ? S_MV_UP : S_MV_DN;
                end
            end
            S_MV_UP: begin
                if (UP_Max) begin
                    state_next = S_IDLE;
                end else if (travel_done) begin
                    state_next = S_FAULT;
                end else if (act) begin
                    state_next = S_STOP;
                end
            end
            S_MV_DN: begin
                if (OBS) begin
                    state_next = S_MV_UP;
                end else if (DN_Max) begin
                    state_next = S_IDLE;
                end else if (travel_done) begin
                    state_next = S_FAULT;
                end else if (act) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (act) begin
                    if (!last_dir_up) begin
                        state_next = S_MV_UP;
                    end else if (!OBS) begin
                        state_next = S_MV_DN;
                    end
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
        // A sensor conflict outranks everything, but illegal codes still recover to IDLE.
        if (limit_conflict && (state <= S_FAULT)) begin
            state_next = S_FAULT;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            act_q       <= 1'b0;
            last_dir_up <= 1'b1;
            travel_cnt  <= '0;
        end else begin
            state <= state_next;
            act_q <= Activate;
            if (entering_motion) begin
                last_dir_up <= (state_next == S_MV_UP);
            end
            if (entering_motion) begin
                travel_cnt <= '0;
            end else if (motor_on) begin
                travel_cnt <= (travel_cnt == '1) ? travel_cnt : travel_cnt + 1'b1;
            end else begin
                travel_cnt <= '0;
            end
        end
    end

    assign UP_M  = (state == S_MV_UP);
    assign DN_M  = (state == S_MV_DN);
    assign FAULT = (state == S_FAULT);
    assign STATE = state;

endmodule

// File: tb/tb_agdc_multi_mode.sv
// Self-checking bench for agdc_multi_mode: directed vector table, multi-cycle corner
// sequences and randomized stimulus against a behavioural door model.
module tb_agdc_multi_mode;

    localparam int CNT_W          = 16;
    localparam int TRAVEL_CYC     = 8;
    localparam int AUTO_CLOSE_CYC = 16;
    localparam int N_TBL          = 23;
    localparam int N_RAND         = 3000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Activate;
    logic       UP_Max;
    logic       DN_Max;
    logic       OBS;
    logic       UP_M;
    logic       DN_M;
    logic       FAULT;
    logic [2:0] STATE;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic a;
        logic up;
        logic dn;
        logic obs;
        int   exp_state;
    } vec_t;

    vec_t tbl [N_TBL];

    // Behavioural model state: 0 idle, 1 opening, 2 closing, 3 stopped, 4 fault.
    int m_state;
    bit m_aq;
    bit m_last_up;
    int m_travel;
    int m_auto;

    agdc_multi_mode #(
        .CNT_W         (CNT_W),
        .TRAVEL_CYC    (TRAVEL_CYC),
        .AUTO_CLOSE_CYC(AUTO_CLOSE_CYC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Activate(Activate),
        .UP_Max  (UP_Max),
        .DN_Max  (DN_Max),
        .OBS     (OBS),
        .UP_M    (UP_M),
        .DN_M    (DN_M),
        .FAULT   (FAULT),
        .STATE   (STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input int exp_state);
        check({name, ".STATE"}, int'(STATE), exp_state);
        check({name, ".UP_M"},  int'(UP_M),  int'(exp_state == 1));
        check({name, ".DN_M"},  int'(DN_M),  int'(exp_state == 2));
        check({name, ".FAULT"}, int'(FAULT), int'(exp_state == 4));
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_aq      = 1'b0;
        m_last_up = 1'b1;
        m_travel  = 0;
        m_auto    = 0;
    endtask

    task automatic model_step();
        int ns;
        bit act;
        bit arm;
        bit auto_to;
        bit tr_to;
        act     = Activate && !m_aq;
        tr_to   = (m_travel >= TRAVEL_CYC - 1);
        arm     = (m_state == 0) && UP_Max && !DN_Max && !OBS;
`ifdef AGDC_AUTO_CLOSE_EN
        auto_to = arm && (m_auto >= AUTO_CLOSE_CYC - 1);
`else
        auto_to = 1'b0;
`endif
        ns = m_state;
        if (UP_Max && DN_Max) ns = 4;
        else if (m_state == 0) begin
            if (auto_to) ns = 2;
            else if (act) ns = UP_Max ? 2 : 1;
        end else if (m_state == 1) begin
            if (UP_Max) ns = 0;
            else if (tr_to) ns = 4;
            else if (act) ns = 3;
        end else if (m_state == 2) begin
            if (OBS) ns = 1;
            else if (DN_Max) ns = 0;
            else if (tr_to) ns = 4;
            else if (act) ns = 3;
        end else if (m_state == 3) begin
            if (act) ns = !m_last_up ? 1 : (OBS ? 3 : 2);
        end
        if ((ns == 1 || ns == 2) && ns != m_state) begin
            m_travel  = 0;
            m_last_up = (ns == 1);
        end else if (m_state == 1 || m_state == 2) begin
            m_travel = (m_travel < 65535) ? m_travel + 1 : m_travel;
        end else begin
            m_travel = 0;
        end
        if (arm && ns == 0) m_auto = (m_auto < 65535) ? m_auto + 1 : m_auto;
        else m_auto = 0;
        m_aq    = Activate;
        m_state = ns;
    endtask

    // Drive inputs mid-cycle, then sample 1 ns after the next rising edge.
    task automatic apply(input logic a, input logic up, input logic dn, input logic obs);
        @(negedge CLK);
        Activate = a;
        UP_Max   = up;
        DN_Max   = dn;
        OBS      = obs;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input string name);
        @(negedge CLK);
        RST      = 1'b0;
        Activate = 1'b0;
        UP_Max   = 1'b0;
        DN_Max   = 1'b0;
        OBS      = 1'b0;
        #1;
        check_state(name, 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        RST      = 1'b0;
        Activate = 1'b0;
        UP_Max   = 1'b0;
        DN_Max   = 1'b0;
        OBS      = 1'b0;
        model_reset();
        #1;
        check_state("por", 0);
        @(negedge CLK);
        RST = 1'b1;

        // {Activate, UP_Max, DN_Max, OBS, expected state after the edge}
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 3};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 3};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 4};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4};

        for (int i = 0; i < N_TBL; i++) begin
            apply(tbl[i].a, tbl[i].up, tbl[i].dn, tbl[i].obs);
            check_state($sformatf("tbl[%0d]", i), tbl[i].exp_state);
        end

        // Held button from closed: exactly one act, then open limit parks it.
        do_reset("held_rst");
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        check_state("held_pre", 0);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        check_state("held_go", 1);
        for (int k = 0; k < 6; k++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0);
            check_state($sformatf("held_up[%0d]", k), 1);
        end
        for (int k = 0; k < 13; k++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            check_state($sformatf("held_idle[%0d]", k), 0);
        end

        // Travel timeout: fault on the TRAVEL_CYC-th motor cycle, sticky until reset.
        do_reset("tmo_rst");
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        check_state("tmo_go", 1);
        for (int k = 1; k < TRAVEL_CYC; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            check_state($sformatf("tmo_run[%0d]", k), 1);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check_state("tmo_fault", 4);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check_state("tmo_act", 4);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        check_state("tmo_sens", 4);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        check_state("tmo_act2", 4);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_state("tmo_clear", 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;

        // Obstruction while closing reverses on the next edge.
        do_reset("obs_rst");
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        check_state("obs_go", 2);
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            check_state($sformatf("obs_dn[%0d]", k), 2);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        check_state("obs_rev", 1);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        check_state("obs_open", 0);

        // Limit conflict from closing and from idle.
        do_reset("cfl_rst");
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        check_state("cfl_dn", 2);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        check_state("cfl_dn_fault", 4);
        do_reset("cfl_rst2");
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        check_state("cfl_idle_fault", 4);

        // Asynchronous reset while opening kills the motor without a clock edge.
        do_reset("arst_rst");
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check_state("arst_up", 1);
        #2;
        RST = 1'b0;
        #1;
        check_state("arst_now", 0);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            check_state($sformatf("arst_hold[%0d]", k), 0);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check_state("arst_act", 1);

`ifdef AGDC_AUTO_CLOSE_EN
        do_reset("ac_rst");
        for (int k = 1; k < AUTO_CLOSE_CYC; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            check_state($sformatf("ac_wait[%0d]", k), 0);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        check_state("ac_close", 2);
        do_reset("ac_rst2");
        for (int k = 1; k < 10; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            check_state($sformatf("ac_pre[%0d]", k), 0);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        check_state("ac_obs", 0);
        for (int k = 1; k < AUTO_CLOSE_CYC; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            check_state($sformatf("ac_restart[%0d]", k), 0);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        check_state("ac_close2", 2);
`else
        do_reset("noac_rst");
        for (int k = 0; k < 40; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            check_state($sformatf("noac_idle[%0d]", k), 0);
        end
`endif

        // Randomized traffic against the behavioural model.
        do_reset("rand_rst0");
        begin
            int fault_run;
            fault_run = 0;
            for (int i = 0; i < N_RAND; i++) begin
                @(negedge CLK);
                if ($urandom_range(0, 3) == 0) Activate = ~Activate;
                if ($urandom_range(0, 5) == 0) UP_Max = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 5) == 0) DN_Max = ($urandom_range(0, 4) == 0);
                OBS = ($urandom_range(0, 7) == 0);
                fault_run = (m_state == 4) ? fault_run + 1 : 0;
                if (fault_run >= 8 || $urandom_range(0, 199) == 0) begin
                    RST = 1'b0;
                    #1;
                    model_reset();
                    check_state($sformatf("rand_rst[%0d]", i), m_state);
                    RST = 1'b1;
                    fault_run = 0;
                end
                @(posedge CLK);
                #1;
                model_step();
                check_state($sformatf("rand[%0d]", i), m_state);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/agdc_multi_mode.md
AGDC_MULTI_MODE -- requirements
Module: agdc_multi_mode

Interface
REQ-001 Parameter: CNT_W, 16, width of the travel and auto-close counters.
REQ-002 Parameter: TRAVEL_CYC, 1000, maximum motor-on cycles before a travel timeout.
REQ-003 Parameter: AUTO_CLOSE_CYC, 5000, cycles the door stays open before auto-close.
REQ-004 Port: CLK  input  1  clock; all state updates on the rising edge.
REQ-005 Port: RST  input  1  reset, asynchronous, active-low.
REQ-006 Port: Activate  input  1  user push-button, level; only its rising edge is used.
REQ-007 Port: UP_Max  input  1  fully-open limit sensor, active-high.
REQ-008 Port: DN_Max  input  1  fully-closed limit sensor, active-high.
REQ-009 Port: OBS  input  1  obstruction sensor (beam broken), active-high.
REQ-010 Port: UP_M  output  1  up-motor enable.
REQ-011 Port: DN_M  output  1  down-motor enable.
REQ-012 Port: FAULT  output  1  fault indicator.
REQ-013 Port: STATE  output  3  current state code.

Function
REQ-014 Block SHALL be a Moore FSM; UP_M, DN_M, FAULT and STATE SHALL decode the state register only.
REQ-015 States and codes SHALL be IDLE=0, MV_UP=1, MV_DN=2, STOP=3, FAULT=4; codes 5-7 SHALL go to IDLE on the next edge with motors off.
REQ-016 Motor outputs: MV_UP gives UP_M=1; MV_DN gives DN_M=1; all other states give UP_M=DN_M=0; UP_M&DN_M SHALL never be 1 together.
REQ-017 FAULT output SHALL be 1 only in state FAULT.
REQ-018 act = Activate & !act_q, with act_q a registered copy of Activate; a held button SHALL produce one act only.
REQ-019 Transition priority SHALL be: UP_Max&DN_Max=1 from any state goes to FAULT; then OBS; then limit; then timeout; then act.
REQ-020 IDLE on act: DN_Max=1 goes to MV_UP; UP_Max=1 goes to MV_DN; both 0 (mid-travel) goes to MV_UP.
REQ-021 MV_UP: UP_Max=1 goes to IDLE; act goes to STOP; OBS is ignored.
REQ-022 MV_DN: OBS=1 goes to MV_UP (reversal, next edge); DN_Max=1 goes to IDLE; act goes to STOP.
REQ-023 STOP on act SHALL go to the direction opposite the last motion; last_dir SHALL be a register updated on entry to MV_UP/MV_DN; OBS SHALL block entry to MV_DN (stay in STOP).
REQ-024 Travel counter SHALL clear on entry to MV_UP/MV_DN and increment each motor-on cycle; reaching TRAVEL_CYC-1 without the limit SHALL go to FAULT on the next edge.
REQ-025 Counters SHALL saturate, never wrap; TRAVEL_CYC and AUTO_CLOSE_CYC SHALL be at most 2^CNT_W-1.
REQ-026 FAULT SHALL be exited only by reset; act, OBS and sensor inputs SHALL be ignored in FAULT.

Reset
REQ-027 RST low SHALL immediately force IDLE, act_q=0, last_dir=up, counters=0, UP_M=DN_M=FAULT=0, STATE=0.
REQ-028 RST asserted mid-travel SHALL stop motors asynchronously; after release the door SHALL stay in IDLE until act.

Configuration
REQ-029 With macro AGDC_AUTO_CLOSE_EN defined: in IDLE with UP_Max=1, DN_Max=0, OBS=0, the auto-close counter SHALL increment; reaching AUTO_CLOSE_CYC-1 SHALL go to MV_DN; OBS=1 or leaving IDLE SHALL clear it.
REQ-030 With AGDC_AUTO_CLOSE_EN undefined: no auto-close counter SHALL exist, and IDLE SHALL be left only on act or a sensor conflict.

Verification
REQ-031 DN_Max=1, Activate 0->1 held 20 cycles -> MV_UP one edge later, single act; UP_Max=1 -> IDLE, UP_M=0.
REQ-032 Closing, OBS=1 at cycle 10 of MV_DN -> next edge STATE=1, UP_M=1, DN_M=0.
REQ-033 TRAVEL_CYC=8, MV_UP with UP_Max held 0 -> STATE=4, FAULT=1 after 8 motor cycles; act ignored; RST low clears it.
REQ-034 MV_DN, act -> STOP (motors 0); second act -> MV_UP.
REQ-035 AGDC_AUTO_CLOSE_EN, AUTO_CLOSE_CYC=16, open IDLE -> MV_DN after 16 cycles; OBS pulse at cycle 10 restarts the count.
REQ-036 UP_Max=DN_Max=1 in any state -> FAULT next edge; RST low mid-MV_UP -> UP_M=0 immediately.
